// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide sequencer that owns the HI/LO result registers.
// It produces one result bit per cycle: shift-add multiply and restoring divide on operand magnitudes.
module mult_div_unit #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1,
  parameter int CNT_W  = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DZ} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 op_q;
  logic                 neg_a_q;
  logic                 neg_b_q;
  logic [WIDTH-1:0]     opnd_q;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q;     // product accumulator; low half is the quotient when dividing
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dz_q;

  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       mul_sum_d;
  logic [2*WIDTH-1:0]   mul_step_d;
  logic [WIDTH:0]       div_shift_d;
  logic                 div_ge_d;
  logic [WIDTH-1:0]     rem_step_d;
  logic [WIDTH-1:0]     quo_step_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     fix_hi_d;
  logic [WIDTH-1:0]     fix_lo_d;

  // The magnitude of MIN wraps to itself, which reads correctly as 2^(WIDTH-1) unsigned.
  assign sign_a = SIGNED && a[WIDTH-1];
  assign sign_b = SIGNED && b[WIDTH-1];
  assign mag_a  = sign_a ? -a : a;
  assign mag_b  = sign_b ? -b : b;

  always_comb begin
    mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_step_d  = acc_q[0] ? {mul_sum_d, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    div_shift_d = {rem_q, acc_q[WIDTH-1]};
    div_ge_d    = div_shift_d >= {1'b0, opnd_q};
    rem_step_d  = div_ge_d ? WIDTH'(div_shift_d - {1'b0, opnd_q}) : div_shift_d[WIDTH-1:0];
    quo_step_d  = {acc_q[WIDTH-2:0], div_ge_d};

    // Quotient sign follows the operand signs; remainder follows the dividend (truncation toward zero).
    prod_d      = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_d       = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d       = neg_a_q ? -rem_q : rem_q;
    fix_hi_d    = op_q ? rem_d : prod_d[2*WIDTH-1:WIDTH];
    fix_lo_d    = op_q ? quo_d : prod_d[WIDTH-1:0];
  end

  // NOTE: working registers are cleared on reset too, so an abandoned operation leaves no residue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            neg_a_q <= sign_a;
            neg_b_q <= sign_b;
            opnd_q  <= op ? mag_b : mag_a;
            acc_q   <= {{WIDTH{1'b0}}, (op ? mag_a : mag_b)};
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (op && (b == '0)) ? DZ : RUN;
          end
        end
        RUN: begin
          acc_q <= op_q ? {{WIDTH{1'b0}}, quo_step_d} : mul_step_d;
          if (op_q) rem_q <= rem_step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        DZ: begin
          done_q  <= 1'b1;
          dz_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
